// File: rtl/var_delay_pkg.sv
// Shared types and read-address helper for the var_delay_mem programmable delay line.
package var_delay_pkg;

  localparam int DEF_MAX_LEN = 16;
  localparam int DEF_LW      = $clog2(DEF_MAX_LEN + 1);
  localparam int DEF_PW      = $clog2(DEF_MAX_LEN);

  typedef logic [DEF_LW-1:0] dly_t;
  typedef logic [DEF_PW-1:0] ptr_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Oldest-wanted slot: wp - (d-1) modulo a power-of-two depth.
  function automatic int rd_addr(input int wp, input int d, input int max_len);
    return (wp + max_len - (d - 1)) & (max_len - 1);
  endfunction

endpackage

// File: rtl/var_delay_mem_sdp_ram_rf.sv
// Simple dual-port register file: synchronous write, asynchronous read.
module sdp_ram_rf #(
  parameter int DW    = 8,
  parameter int WORDS = 16,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [WORDS];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/var_delay_mem.sv
// Runtime-programmable enable-qualified delay line over a register-file RAM.
// Optional sticky out-of-range flag `dly_err` when VAR_DELAY_MEM_ERR_EN is defined.
module var_delay_mem
  import var_delay_pkg::*;
#(
  parameter int DW      = 8,
  parameter int MAX_LEN = 16,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] din,
  input  logic          dly_ld,
  input  logic [LW-1:0] dly,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic [LW-1:0] fill,
`ifdef VAR_DELAY_MEM_ERR_EN
  output logic          dly_err,
`endif
  output logic          o_dbg_state
);

  localparam int            PW    = $clog2(MAX_LEN);
  localparam logic [LW-1:0] MAX_D = LW'(MAX_LEN);

  generate
    if (MAX_LEN < 2 || (MAX_LEN & (MAX_LEN - 1)) != 0) begin : g_bad_len
      $error("var_delay_mem: MAX_LEN must be a power of two and >= 2");
    end
  endgenerate

  logic [PW-1:0] r_wp;
  logic [PW-1:0] w_rp;
  logic [LW-1:0] r_d;
  logic [LW-1:0] r_fill;
  logic [LW-1:0] w_ld_d;
  logic [LW-1:0] w_fill_inc;
  logic [DW-1:0] r_dout;
  logic [DW-1:0] w_rd_data;
  logic          w_oor;
  state_e        r_state;

  assign w_oor      = (dly > MAX_D);
  assign w_ld_d     = w_oor ? MAX_D : dly;
  assign w_rp       = PW'(rd_addr(int'(r_wp), int'(r_d), MAX_LEN));
  assign w_fill_inc = (r_fill == r_d) ? r_fill : r_fill + 1'b1;

  sdp_ram_rf #(
    .DW   (DW),
    .WORDS(MAX_LEN)
  ) u_ram (
    .clk    (clk),
    .i_we   (en && !rst),
    .i_waddr(r_wp),
    .i_wdata(din),
    .i_raddr(w_rp),
    .o_rdata(w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_d     <= LW'(1);
      r_fill  <= '0;
      r_dout  <= '0;
      r_state <= FILL;
    end else begin
      if (en) r_wp <= r_wp + 1'b1;
      // wp keeps running across loads; fill masks whatever stale data it points at.
      if (dly_ld) begin
        r_d <= w_ld_d;
        if (w_ld_d == '0) begin
          r_fill  <= '0;
          r_dout  <= '0;
          r_state <= RUN;
        end else if (en && w_ld_d == LW'(1)) begin
          r_fill  <= LW'(1);
          r_dout  <= din;
          r_state <= RUN;
        end else begin
          r_fill  <= en ? LW'(1) : '0;
          r_dout  <= '0;
          r_state <= FILL;
        end
      end else if (en && r_d != '0) begin
        r_fill <= w_fill_inc;
        // The sample that completes the fill is the first one presented.
        if (w_fill_inc == r_d) begin
          r_dout  <= (r_d == LW'(1)) ? din : w_rd_data;
          r_state <= RUN;
        end else begin
          r_dout <= '0;
        end
      end
    end
  end

`ifdef VAR_DELAY_MEM_ERR_EN
  logic r_dly_err;
  always_ff @(posedge clk) begin
    if (rst)         r_dly_err <= 1'b0;
    else if (dly_ld) r_dly_err <= w_oor;
  end
  assign dly_err = r_dly_err;
`endif

  assign dout        = (r_d == '0) ? din : r_dout;
  assign dout_vld    = (r_state == RUN);
  assign fill        = r_fill;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_var_delay_mem.sv
// Self-checking bench for var_delay_mem: reference model feeds an expected queue per step.
module tb_var_delay_mem;

  localparam int DW      = 8;
  localparam int MAX_LEN = 16;
  localparam int LW      = $clog2(MAX_LEN + 1);

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] din;
  logic          dly_ld;
  logic [LW-1:0] dly;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic [LW-1:0] fill;
  logic          dbg_state;
`ifdef VAR_DELAY_MEM_ERR_EN
  logic          dly_err;
`endif

  always #5 clk = ~clk;

  var_delay_mem #(
    .DW     (DW),
    .MAX_LEN(MAX_LEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .dly_ld     (dly_ld),
    .dly        (dly),
    .dout       (dout),
    .dout_vld   (dout_vld),
    .fill       (fill),
`ifdef VAR_DELAY_MEM_ERR_EN
    .dly_err    (dly_err),
`endif
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_steps = 0;

  logic [DW+LW:0] exp_q[$];  // {dout, dout_vld, fill}

  int            m_d = 1;
  int            m_fill = 0;
  logic [DW-1:0] m_dout = '0;
  logic          m_vld = 1'b0;
  logic          m_err = 1'b0;
  logic [DW-1:0] m_hist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: dout after an en edge is the D-th most recent accepted
  // sample (the current one counting as the first) once D samples are held.
  task automatic model(input logic r, input logic e, input logic l,
                       input logic [DW-1:0] d_in, input int dl);
    int nd;
    if (r) begin
      m_d = 1; m_fill = 0; m_dout = '0; m_vld = 1'b0; m_err = 1'b0;
      m_hist.delete();
    end else if (l) begin
      nd    = (dl > MAX_LEN) ? MAX_LEN : dl;
      m_err = (dl > MAX_LEN);
      m_d   = nd;
      m_hist.delete();
      if (e) m_hist.push_back(d_in);
      m_fill = (nd == 0) ? 0 : (e ? 1 : 0);
      m_vld  = (nd == 0) || (m_fill == nd);
      m_dout = (e && nd == 1) ? d_in : '0;
    end else if (e) begin
      m_hist.push_back(d_in);
      if (m_d != 0) begin
        if (m_fill < m_d) m_fill++;
        if (m_fill == m_d) begin
          m_dout = m_hist[m_hist.size() - m_d];
          m_vld  = 1'b1;
        end else begin
          m_dout = '0;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic e, input logic l,
                      input logic [DW-1:0] d_in, input int dl);
    logic [DW+LW:0] got_v;
    rst = r; en = e; dly_ld = l; din = d_in; dly = LW'(dl);
    model(r, e, l, d_in, dl);
    exp_q.push_back({(m_d == 0) ? d_in : m_dout, m_vld, LW'(m_fill)});
    @(posedge clk);
    #1;
    n_steps++;
    got_v = {dout, dout_vld, fill};
    check($sformatf("step%0d dout/vld/fill", n_steps), 32'(got_v), 32'(exp_q.pop_front()));
`ifdef VAR_DELAY_MEM_ERR_EN
    check($sformatf("step%0d dly_err", n_steps), 32'(dly_err), 32'(m_err));
`endif
  endtask

  // Pass-through: dout must follow din with no clock edge.
  task automatic comb_check(input logic [DW-1:0] v);
    din = v;
    #1;
    check("comb dout", 32'(dout), 32'(v));
    check("comb vld", 32'(dout_vld), 32'(1'b1));
  endtask

  logic e_pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; en = 1'b0; dly_ld = 1'b0; din = '0; dly = '0;

    step(1'b1, 1'b0, 1'b0, 8'h00, 0);
    step(1'b1, 1'b1, 1'b0, 8'h55, 0);

    // D=3 with a continuous stream
    step(1'b0, 1'b0, 1'b1, 8'h00, 3);
    for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 1'b0, 8'(i), 0);

    // D=1 with gapped enable
    step(1'b0, 1'b0, 1'b1, 8'h00, 1);
    for (int i = 0; i < 5; i++) step(1'b0, e_pat[i], 1'b0, 8'(8'hA + i), 0);

    // D=MAX_LEN across two pointer wraps
    step(1'b0, 1'b0, 1'b1, 8'h00, MAX_LEN);
    for (int i = 0; i <= 40; i++) step(1'b0, 1'b1, 1'b0, 8'(i), 0);

    // D=0 pass-through, then reload D=2 mid-stream
    step(1'b0, 1'b0, 1'b1, 8'h00, 0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'(i % 2), 1'b0, 8'($urandom_range(0, 255)), 0);
      comb_check(8'($urandom_range(0, 255)));
    end
    step(1'b0, 1'b0, 1'b1, 8'h00, 2);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h20 + i), 0);

    // load and enable in the same cycle
    step(1'b0, 1'b1, 1'b1, 8'h40, 4);
    for (int i = 0; i < 8; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'(8'h41 + i), 0);

    // out-of-range load clamps; in-range load clears the flag
    step(1'b0, 1'b0, 1'b1, 8'h00, 20);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 8'(i * 3), 0);
    step(1'b0, 1'b0, 1'b1, 8'h00, 5);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h80 + i), 0);

    // reset mid-stream
    step(1'b1, 1'b1, 1'b0, 8'hFF, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i), 0);

    // random mix of enables and loads
    for (int i = 0; i < 120; i++) begin
      step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 11) == 0),
           8'($urandom_range(0, 255)), int'($urandom_range(0, 20)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
